// File: rtl/jtpang_objdma.sv
// Object attribute DMA: copies 2^AW bytes from the CPU-shared RAM into
// the object buffer while holding the Z80 bus. Two cen steps per byte.
//
// Ports:
//   clk, rst_n, cen         clock, async active-low reset, clock enable
//   dma_go                  CPU strobe, rising edge starts a transfer
//   busrq_n / busak_n       Z80 bus request / acknowledge (active low)
//   src_addr/src_cs/src_dout  source RAM read port
//   obj_addr/obj_din/obj_we   object buffer write port
//   busy, done              status: transfer in flight / finished pulse
module jtpang_objdma #(
  parameter int          AW       = 9,
  parameter logic [11:0] SRC_BASE = 12'h000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_go,
  output logic          busrq_n,
  input  logic          busak_n,
  output logic [11:0]   src_addr,
  output logic          src_cs,
  input  logic [7:0]    src_dout,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_din,
  output logic          obj_we,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE, REQ, READ, WRITE, REL
  } state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        st_q, st_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          go_q, go_d;
  logic          start, bus_ok;

  // go_q resets to 1 so a strobe held through reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      go_q   <= 1'b1;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      go_q   <= go_d;
    end
  end

  always_comb begin
    go_d   = dma_go;
    start  = dma_go & ~go_q;
    bus_ok = ~busak_n;
    st_d   = st_q;
    cnt_d  = cnt_q;
    // every edge is remembered until a transfer actually begins
    pend_d = pend_q | start;
    unique case (st_q)
      IDLE: begin
        if (cen && (start || pend_q)) begin
          st_d   = REQ;
          cnt_d  = '0;
          pend_d = 1'b0;
        end
      end
      REQ: begin
        if (cen && bus_ok) st_d = READ;
      end
      READ: begin
        if (cen && bus_ok) st_d = WRITE;
      end
      WRITE: begin
        if (cen && bus_ok) begin
          cnt_d = cnt_q + ONE;
          st_d  = (cnt_q == '1) ? REL : READ;
        end
      end
      REL: begin
        if (cen && busak_n) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // a lost acknowledge mid-copy freezes the port outputs too
  assign busy     = (st_q != IDLE);
  assign busrq_n  = ~((st_q == REQ) || (st_q == READ)
                      || (st_q == WRITE));
  assign src_cs   = (st_q == READ) && bus_ok;
  assign src_addr = SRC_BASE + 12'(cnt_q);
  assign obj_we   = (st_q == WRITE) && cen && bus_ok;
  assign obj_addr = cnt_q;
  assign obj_din  = (st_q == WRITE) ? src_dout : 8'h00;
  assign done     = (st_q == REL) && cen && busak_n;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Scoreboard bench for jtpang_objdma: default instance plus a small
// AW=5 instance whose source window wraps past 12'hFFF.
module tb_jtpang_objdma;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b1;
  logic       dma_go = 1'b0;
  logic       busrq_n;
  logic       busak_n = 1'b1;
  logic [11:0] src_addr;
  logic       src_cs;
  logic [7:0] src_dout = 8'h00;
  logic [8:0] obj_addr;
  logic [7:0] obj_din;
  logic       obj_we, busy, done;

  logic       dma_go2 = 1'b0;
  logic       busrq_n2;
  logic       busak_n2 = 1'b1;
  logic [11:0] src_addr2;
  logic       src_cs2;
  logic [7:0] src_dout2 = 8'h00;
  logic [4:0] obj_addr2;
  logic [7:0] obj_din2;
  logic       obj_we2, busy2, done2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cen_div = 1;
  int ack_cnt = 0;
  int gap_at = -1;
  int gap_left = 0;
  bit gap_fired = 1'b0;
  int wr_cnt = 0, done_cnt = 0, cen_bad = 0;
  int gap_bad = 0, steps = 0, wr2_cnt = 0;

  logic [19:0] sbq[$];
  logic [19:0] sbq2[$];
  logic [11:0] saq2[$];
  logic [19:0] sb_e, sb_e2;
  logic [11:0] sa_e;

  always #5 clk = ~clk;

  jtpang_objdma u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .dma_go(dma_go), .busrq_n(busrq_n),
    .busak_n(busak_n), .src_addr(src_addr),
    .src_cs(src_cs), .src_dout(src_dout),
    .obj_addr(obj_addr), .obj_din(obj_din),
    .obj_we(obj_we), .busy(busy), .done(done)
  );

  jtpang_objdma #(.AW(5), .SRC_BASE(12'hFF0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cen(1'b1),
    .dma_go(dma_go2), .busrq_n(busrq_n2),
    .busak_n(busak_n2), .src_addr(src_addr2),
    .src_cs(src_cs2), .src_dout(src_dout2),
    .obj_addr(obj_addr2), .obj_din(obj_din2),
    .obj_we(obj_we2), .busy(busy2), .done(done2)
  );

  function automatic logic [7:0] pat(input logic [11:0] a);
    return a[7:0] ^ {4'h0, a[11:8]} ^ 8'hA5;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // synchronous source RAMs, read on an enabled edge
  always @(posedge clk) begin
    if (cen && src_cs) src_dout <= pat(src_addr);
    if (src_cs2) src_dout2 <= pat(src_addr2);
  end

  // bus arbiter and cen generator, updated just after the edge
  always @(posedge clk) begin
    #1;
    if (busrq_n) begin
      busak_n = 1'b1;
      ack_cnt = 0;
    end else begin
      if (cen && ack_cnt < 3) ack_cnt++;
      if (ack_cnt >= 3) busak_n = 1'b0;
    end
    if (!gap_fired && gap_at >= 0 && wr_cnt == gap_at) begin
      gap_left = 10;
      gap_fired = 1'b1;
    end
    if (gap_left > 0) begin
      busak_n = 1'b1;
      if (cen) gap_left--;
    end
    busak_n2 = busrq_n2;
    cyc++;
    cen = (cyc % cen_div) == 0;
  end

  always @(posedge clk)
    if (cen && !busak_n && !busrq_n) steps++;

  always @(negedge clk) begin
    if (obj_we) begin
      wr_cnt++;
      if (!cen) cen_bad++;
      if (gap_left > 0) gap_bad++;
      if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
      else begin
        sb_e = sbq.pop_front();
        chk("obj_addr", 32'(obj_addr), 32'(sb_e[19:8]));
        chk("obj_din", 32'(obj_din), 32'(sb_e[7:0]));
      end
    end
    if (done) done_cnt++;
    if (obj_we2) begin
      wr2_cnt++;
      if (sbq2.size() == 0) chk("sb2_underflow", sbq2.size(), 1);
      else begin
        sb_e2 = sbq2.pop_front();
        chk("obj_addr2", 32'(obj_addr2), 32'(sb_e2[19:8]));
        chk("obj_din2", 32'(obj_din2), 32'(sb_e2[7:0]));
      end
    end
    if (src_cs2) begin
      if (saq2.size() == 0) chk("sa2_underflow", saq2.size(), 1);
      else begin
        sa_e = saq2.pop_front();
        chk("src_addr2", 32'(src_addr2), 32'(sa_e));
      end
    end
  end

  task automatic push_main();
    for (int i = 0; i < 512; i++)
      sbq.push_back({12'(i), pat(12'(i))});
  endtask

  task automatic pulse_go();
    @(negedge clk);
    dma_go = 1'b1;
    repeat (3) @(negedge clk);
    dma_go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("went_busy", busy, 1);
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("went_idle", busy, 0);
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_cnt < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr", 32'(wr_cnt >= target), 1);
  endtask

  initial begin
    int w0, d0, s0, c0, g0;
    #1;
    chk("rst_busrq_n", busrq_n, 1);
    chk("rst_src_cs", src_cs, 0);
    chk("rst_obj_we", obj_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_obj_addr", 32'(obj_addr), 0);
    chk("rst_obj_din", 32'(obj_din), 0);
    chk("rst_src_addr", 32'(src_addr), 0);
    chk("rst_src_addr2", 32'(src_addr2), 32'h0FF0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic transfer, cen every clk
    w0 = wr_cnt; d0 = done_cnt;
    push_main();
    pulse_go();
    wait_idle(5000);
    chk("t1_writes", 32'(wr_cnt - w0), 512);
    chk("t1_done", 32'(done_cnt - d0), 1);
    chk("t1_busrq_n", busrq_n, 1);
    chk("t1_sb_left", sbq.size(), 0);

    // cen 1-in-4
    cen_div = 4;
    repeat (8) @(negedge clk);
    w0 = wr_cnt; s0 = steps; c0 = cen_bad;
    push_main();
    pulse_go();
    wait_idle(20000);
    chk("t2_steps", 32'(steps - s0), 2 * 512 + 1);
    chk("t2_we_cen", 32'(cen_bad - c0), 0);
    chk("t2_writes", 32'(wr_cnt - w0), 512);
    cen_div = 1;
    repeat (8) @(negedge clk);

    // two extra strobes mid-transfer coalesce to one rerun
    w0 = wr_cnt; d0 = done_cnt;
    push_main();
    pulse_go();
    wait_wr(w0 + 50);
    push_main();
    pulse_go();
    wait_wr(w0 + 150);
    pulse_go();
    begin
      int n = 0;
      while (!done && n < 5000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t3_saw_done", done, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t3_restart_rq", busrq_n, 0);
    wait_idle(5000);
    chk("t3_done", 32'(done_cnt - d0), 2);
    chk("t3_writes", 32'(wr_cnt - w0), 1024);
    chk("t3_sb_left", sbq.size(), 0);
    repeat (20) @(negedge clk);
    chk("t3_no_third", busy, 0);

    // acknowledge dropped for 10 cen at byte 100
    w0 = wr_cnt; g0 = gap_bad;
    gap_at = w0 + 100;
    push_main();
    pulse_go();
    wait_idle(5000);
    chk("t4_gap_fired", gap_fired, 1);
    chk("t4_gap_writes", 32'(gap_bad - g0), 0);
    chk("t4_writes", 32'(wr_cnt - w0), 512);
    chk("t4_sb_left", sbq.size(), 0);

    // reset in the middle of a transfer
    w0 = wr_cnt;
    push_main();
    pulse_go();
    wait_wr(w0 + 300);
    rst_n = 1'b0;
    #1;
    chk("t5_busrq_n", busrq_n, 1);
    chk("t5_obj_we", obj_we, 0);
    chk("t5_busy", busy, 0);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (100) @(negedge clk);
    chk("t5_no_resume", 32'(wr_cnt - w0), 0);
    chk("t5_idle_rq", busrq_n, 1);

    // strobe held high through reset release
    rst_n = 1'b0;
    dma_go = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (50) @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_busrq_n", busrq_n, 1);
    dma_go = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_writes", 32'(wr_cnt - w0), 0);

    // small instance, wrapping source window
    for (int i = 0; i < 32; i++) begin
      logic [11:0] a;
      a = 12'hFF0 + 12'(i);
      saq2.push_back(a);
      sbq2.push_back({12'(i), pat(a)});
    end
    w0 = wr2_cnt;
    @(negedge clk);
    dma_go2 = 1'b1;
    @(negedge clk);
    dma_go2 = 1'b0;
    begin
      int n = 0;
      while (!busy2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t7_busy", busy2, 1);
      n = 0;
      while (busy2 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("t7_idle", busy2, 0);
    end
    chk("t7_writes", 32'(wr2_cnt - w0), 32);
    chk("t7_sb_left", sbq2.size(), 0);
    chk("t7_sa_left", saq2.size(), 0);
    chk("t7_busrq_n", busrq_n2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtpang_objdma.md
JTPANG_OBJDMA -- requirements
Module: jtpang_objdma

Interface
REQ-001 Parameter AW, default 9, meaning log2 of transfer length in bytes (512 bytes, 128 objects x 4).
REQ-002 Parameter SRC_BASE, default 12'h000, meaning first source byte address within the CPU-shared object attribute RAM.
REQ-003 clk  input  1  system clock; all state advances on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cen  input  1  clock enable; FSM steps only on clk edges with cen=1.
REQ-006 dma_go  input  1  CPU I/O strobe requesting a transfer; level, may last several clk.
REQ-007 busrq_n  output  1  Z80 bus request, active low.
REQ-008 busak_n  input  1  Z80 bus acknowledge, active low.
REQ-009 src_addr  output  12  source RAM address.
REQ-010 src_cs  output  1  source RAM read select.
REQ-011 src_dout  input  8  source RAM read data, valid one cen step after src_addr/src_cs.
REQ-012 obj_addr  output  AW  object buffer write address.
REQ-013 obj_din  output  8  object buffer write data.
REQ-014 obj_we  output  1  object buffer write enable, one clk wide.
REQ-015 busy  output  1  high from request until bus release completes.
REQ-016 done  output  1  one-clk pulse when a transfer finishes.

Function
REQ-017 dma_go SHALL be edge-detected on clk (registered copy); a 0->1 transition sets a start event regardless of cen.
REQ-018 States SHALL be IDLE, REQ, READ, WRITE, REL.
REQ-019 IDLE: start event or pending flag -> REQ on next cen; busrq_n drops with the REQ entry; byte counter cleared to 0.
REQ-020 REQ: hold busrq_n=0; on cen with busak_n=0 -> READ; no timeout.
REQ-021 READ: src_cs=1, src_addr=SRC_BASE+counter (12-bit wrap); on cen -> WRITE.
REQ-022 WRITE: on cen, capture src_dout into obj_din, obj_addr=counter, obj_we=1 for that single clk; counter+1; if counter was 2^AW-1 -> REL, else READ.
REQ-023 Throughput: exactly 2 cen steps per byte; 512 bytes = 1024 cen steps after acknowledge.
REQ-024 REL: busrq_n=1, src_cs=0; on cen with busak_n=1 -> IDLE and done pulses one clk.
REQ-025 busak_n=1 while in READ or WRITE SHALL freeze the FSM (no counter advance, no obj_we, src_cs=0) until busak_n=0 returns.
REQ-026 Start event while busy SHALL set a single pending flag (further events coalesce); pending is cleared on entering REQ.
REQ-027 Start event coinciding with REL->IDLE SHALL be captured as pending and restart immediately.
REQ-028 busy=1 in REQ, READ, WRITE, REL; 0 in IDLE.
REQ-029 Outside READ, src_cs=0; outside WRITE-with-cen, obj_we=0.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, busrq_n=1, src_cs=0, obj_we=0, busy=0, done=0, counter=0, pending=0, obj_addr=0, obj_din=0, src_addr=SRC_BASE.
REQ-031 Reset mid-transfer SHALL release the bus immediately; no resume after rst_n returns high.
REQ-032 A dma_go held high through reset release SHALL NOT trigger a transfer (edge register resets to 1-sensitive: reset value of registered dma_go = 1).

Verification
REQ-033 cen every clk, dma_go pulse, busak_n low 3 cen after busrq_n -> 512 obj_we pulses, obj_addr 0..511 in order, obj_din equals source pattern, done once, busrq_n high after.
REQ-034 cen 1-in-4: pulse dma_go -> obj_we only on cen cycles, 1024 cen steps between ack and REL entry.
REQ-035 Second dma_go pulse twice during transfer -> exactly one extra transfer follows, busrq_n reasserted right after release.
REQ-036 busak_n forced high for 10 cen at counter 100 -> no writes during gap, transfer resumes at 100, total still 512.
REQ-037 rst_n low at counter 300 -> busrq_n=1 and obj_we=0 same cycle; after release no activity without new dma_go edge.
REQ-038 SRC_BASE=12'hFF0, AW=5 -> src_addr wraps FF0..FFF,000..00F; 32 writes.
